// File: rtl/diff_ser_out_if.sv
// rtl/diff_ser_out_if.sv - word-set valid/ready handshake into the differential serializer
interface diff_ser_out_if #(
    parameter int NUM_CH     = 1,
    parameter int WORD_WIDTH = 16
);
    logic [NUM_CH*WORD_WIDTH-1:0] s_data;
    logic                         s_valid;
    logic                         s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/diff_ser_out.sv
// rtl/diff_ser_out.sv - lockstep multi-channel MSB-first serializer with forwarded SCK and frame on LVDS pad pairs
module diff_ser_out #(
    parameter int                NUM_CH        = 1,
    parameter int                WORD_WIDTH    = 16,
    parameter int                HALF_DIV      = 2,
    parameter int                GAP_CYCLES    = 2,
    parameter logic              IDLE_LEVEL    = 1'b0,
    parameter logic [NUM_CH-1:0] DATA_INV_MASK = '0,
    parameter logic              SCK_INV       = 1'b0,
    parameter logic              FRAME_INV     = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    diff_ser_out_if.slave     s,
    output logic              busy,
    output logic              sck_p,
    output logic              sck_n,
    output logic              frame_p,
    output logic              frame_n,
    output logic [NUM_CH-1:0] dout_p,
    output logic [NUM_CH-1:0] dout_n
);
    localparam int HW = $clog2(HALF_DIV + 1);
    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [HW-1:0]     HALF_LAST     = HW'(HALF_DIV - 1);
    localparam logic [BW-1:0]     BIT_LAST      = BW'(WORD_WIDTH - 1);
    localparam logic [GW-1:0]     GAP_LAST      = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [NUM_CH-1:0] DATA_IDLE_PAD = {NUM_CH{IDLE_LEVEL}} ^ DATA_INV_MASK;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                            state_q;
    logic [HW-1:0]                     half_cnt_q;
    logic                              phase_q;
    logic [BW-1:0]                     bit_cnt_q;
    logic [GW-1:0]                     gap_cnt_q;
    logic [NUM_CH-1:0][WORD_WIDTH-1:0] shreg_q;

    // Output registers hold pad-level values so they feed the pad buffers with no logic in between.
    logic                              sck_q;
    logic                              frame_q;
    logic [NUM_CH-1:0]                 dout_q;

    logic [NUM_CH-1:0][WORD_WIDTH-1:0] load_word_d;
    logic [NUM_CH-1:0][WORD_WIDTH-1:0] load_rest_d;
    logic [NUM_CH-1:0][WORD_WIDTH-1:0] shift_rest_d;
    logic [NUM_CH-1:0]                 load_msb_d;
    logic [NUM_CH-1:0]                 next_msb_d;

    always_comb begin
        load_word_d  = '0;
        load_rest_d  = '0;
        shift_rest_d = '0;
        load_msb_d   = '0;
        next_msb_d   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load_word_d[i]  = s.s_data[i*WORD_WIDTH +: WORD_WIDTH];
            load_msb_d[i]   = load_word_d[i][WORD_WIDTH-1];
            load_rest_d[i]  = {load_word_d[i][WORD_WIDTH-2:0], 1'b0};
            next_msb_d[i]   = shreg_q[i][WORD_WIDTH-1];
            shift_rest_d[i] = {shreg_q[i][WORD_WIDTH-2:0], 1'b0};
        end
    end

    // The MSB goes straight to the output register on accept; the shift register keeps only the bits still to send.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            half_cnt_q <= '0;
            phase_q    <= 1'b0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            shreg_q    <= '0;
            sck_q      <= SCK_INV;
            frame_q    <= FRAME_INV;
            dout_q     <= DATA_IDLE_PAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s.s_valid) begin
                        state_q    <= ST_SHIFT;
                        half_cnt_q <= '0;
                        phase_q    <= 1'b0;
                        bit_cnt_q  <= '0;
                        shreg_q    <= load_rest_d;
                        sck_q      <= SCK_INV;
                        frame_q    <= ~FRAME_INV;
                        dout_q     <= load_msb_d ^ DATA_INV_MASK;
                    end
                end
                ST_SHIFT: begin
                    if (half_cnt_q != HALF_LAST) begin
                        half_cnt_q <= half_cnt_q + HW'(1);
                    end else begin
                        half_cnt_q <= '0;
                        if (!phase_q) begin
                            phase_q <= 1'b1;
                            sck_q   <= ~SCK_INV;
                        end else if (bit_cnt_q != BIT_LAST) begin
                            phase_q   <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            sck_q     <= SCK_INV;
                            shreg_q   <= shift_rest_d;
                            dout_q    <= next_msb_d ^ DATA_INV_MASK;
                        end else begin
                            // Last high half of the last bit: drop SCK and frame together, no runt edge.
                            phase_q   <= 1'b0;
                            bit_cnt_q <= '0;
                            gap_cnt_q <= '0;
                            sck_q     <= SCK_INV;
                            frame_q   <= FRAME_INV;
                            dout_q    <= DATA_IDLE_PAD;
                            state_q   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q != GAP_LAST) begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end else begin
                        gap_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.s_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    // Differential pad pairs (OBUFDS boundary): P follows the register, N is its complement.
    assign sck_p   = sck_q;
    assign sck_n   = ~sck_q;
    assign frame_p = frame_q;
    assign frame_n = ~frame_q;
    assign dout_p  = dout_q;
    assign dout_n  = ~dout_q;
endmodule
